// File: rtl/mem_access_unit.sv
// Sequenced data-memory access unit: single loads/stores plus word-by-word COPY.
// Requests are validated up front; invalid ones complete in one cycle with an error.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wData,
  input  logic [7:0]  i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rData,
  output logic        o_DMem_we,
  output logic        o_DMem_sByte,
  output logic [31:0] o_DMem_addr,
  output logic [31:0] o_DMem_wData,
  input  logic [31:0] i_DMem_rData
);

  localparam logic [2:0] OpLw   = 3'd0;
  localparam logic [2:0] OpLb   = 3'd1;
  localparam logic [2:0] OpLbu  = 3'd2;
  localparam logic [2:0] OpSw   = 3'd3;
  localparam logic [2:0] OpSb   = 3'd4;
  localparam logic [2:0] OpCopy = 3'd5;

  // Window limit kept at 34 bits so end-address sums never wrap.
  localparam logic [33:0] Limit = 34'd1 << ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StAcc, StCpRd, StCpWr} state_e;

  state_e state_q, state_d;

  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [7:0]  len_q;
  logic [8:0]  cnt_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;

  logic        accept;
  logic        req_word, req_byte, req_copy, req_illegal;
  logic        req_misalign, req_range, req_err;
  logic [33:0] span, src_end, dst_end;
  logic [10:0] off;
  logic        last_word;
  logic        acc_byte, acc_store;

  always_comb begin
    req_word    = (i_op == OpLw) || (i_op == OpSw);
    req_byte    = (i_op == OpLb) || (i_op == OpLbu) || (i_op == OpSb);
    req_copy    = (i_op == OpCopy);
    req_illegal = (i_op > OpCopy);
    span = '0;
    if (req_word) begin
      span = 34'd4;
    end else if (req_byte) begin
      span = 34'd1;
    end else if (req_copy) begin
      span = {24'b0, i_len, 2'b00};
    end
    src_end      = {2'b00, i_addr} + span;
    dst_end      = {2'b00, i_wData} + span;
    req_misalign = (req_word && (i_addr[1:0] != 2'b00)) ||
                   (req_copy && ((i_addr[1:0] != 2'b00) || (i_wData[1:0] != 2'b00)));
    req_range    = (src_end > Limit) || (req_copy && (dst_end > Limit));
    req_err      = req_illegal || req_misalign || req_range;
  end

  assign accept    = i_req && (state_q == StIdle);
  assign off       = {cnt_q, 2'b00};
  assign last_word = ((cnt_q + 9'd1) == {1'b0, len_q});
  assign acc_byte  = (op_q == OpLb) || (op_q == OpLbu) || (op_q == OpSb);
  assign acc_store = (op_q == OpSw) || (op_q == OpSb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept && !req_err) begin
          if (!req_copy) begin
            state_d = StAcc;
          end else if (i_len != 8'd0) begin
            state_d = StCpRd;
          end
        end
      end
      StAcc:  state_d = StIdle;
      StCpRd: state_d = StCpWr;
      StCpWr: state_d = last_word ? StIdle : StCpRd;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy       = (state_q != StIdle);
    o_DMem_we    = 1'b0;
    o_DMem_sByte = 1'b0;
    o_DMem_addr  = '0;
    o_DMem_wData = '0;
    case (state_q)
      StAcc: begin
        o_DMem_addr  = addr_q;
        o_DMem_sByte = acc_byte;
        o_DMem_we    = acc_store;
        o_DMem_wData = data_q;
      end
      StCpRd: begin
        o_DMem_addr = addr_q + {21'b0, off};
      end
      StCpWr: begin
        o_DMem_addr  = data_q + {21'b0, off};
        o_DMem_wData = buf_q;
        o_DMem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        op_q   <= i_op;
        addr_q <= i_addr;
        data_q <= i_wData;
        len_q  <= i_len;
        cnt_q  <= '0;
        if (req_err) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end else if (req_copy && (i_len == 8'd0)) begin
          done_q <= 1'b1;
        end
      end
      case (state_q)
        StAcc: begin
          done_q <= 1'b1;
          case (op_q)
            OpLw:    rdata_q <= i_DMem_rData;
            OpLb:    rdata_q <= {{24{i_DMem_rData[7]}}, i_DMem_rData[7:0]};
            OpLbu:   rdata_q <= {24'b0, i_DMem_rData[7:0]};
            default: ;
          endcase
        end
        StCpRd: buf_q <= i_DMem_rData;
        StCpWr: begin
          cnt_q <= cnt_q + 9'd1;
          if (last_word) begin
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_rData = rdata_q;

endmodule
